// File: rtl/vga_scanout_reader.sv
// Scanout side of the double-buffered 640x480 framebuffer: VGA timing, one read per visible pixel,
// colour aligned to sync/blank after the read latency, optional clear-after-display, and buffer swap.
module vga_scanout_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYN  = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYN  = 2,
  parameter int V_BP   = 33,
  parameter int RD_LAT = 1,
  parameter bit CLR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixEn,
  output logic        rdEn,
  output logic [18:0] rdAddr,
  input  logic [3:0]  rdData,
  output logic        clrWe,
  output logic [18:0] clrAddr,
  output logic        bufSel,
  input  logic        swapReq,
  output logic        swapAck,
  output logic        frameStart,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [3:0]  vgaColor
);

  localparam int H_TOT = H_VIS + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYN + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
  localparam logic [9:0] H_SYN_S  = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYN_E  = 10'(H_VIS + H_FP + H_SYN);
  localparam logic [9:0] V_SYN_S  = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYN_E  = 10'(V_VIS + V_FP + V_SYN);

  typedef struct packed {
    logic        vld;
    logic        hs;
    logic        vs;
    logic        vis;
    logic        rd;
    logic [18:0] addr;
  } pipe_t;

  typedef enum logic [1:0] {SW_IDLE, SW_SWAP, SW_WAIT_LOW} swap_state_e;

  logic [9:0]  hcnt, vcnt;
  logic        visible;
  logic        vblank_entry;
  logic        go_swap;
  pipe_t       stage_in;
  pipe_t       tail;
  pipe_t       pipe [RD_LAT];
  swap_state_e state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pixEn) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign visible    = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
  assign rdEn       = pixEn && visible && !rst;
  assign rdAddr     = visible ? (19'(hcnt) + {vcnt, 9'b0} + {2'b0, vcnt, 7'b0}) : '0;
  assign frameStart = pixEn && !rst && (hcnt == '0) && (vcnt == '0);

  always_comb begin
    stage_in      = '0;
    stage_in.vld  = pixEn;
    stage_in.hs   = !((hcnt >= H_SYN_S) && (hcnt < H_SYN_E));
    stage_in.vs   = !((vcnt >= V_SYN_S) && (vcnt < V_SYN_E));
    stage_in.vis  = visible;
    stage_in.rd   = rdEn;
    stage_in.addr = rdEn ? rdAddr : '0;
  end

  // Pipe advances every clk; only entries tagged vld (a pixEn clk) update the DAC outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      blank    <= 1'b1;
      vgaColor <= '0;
    end else if (tail.vld) begin
      hsync    <= tail.hs;
      vsync    <= tail.vs;
      blank    <= !tail.vis;
      vgaColor <= tail.vis ? rdData : '0;
    end
  end

  assign clrWe   = CLR_EN && tail.rd;
  assign clrAddr = CLR_EN ? tail.addr : '0;

  assign vblank_entry = pixEn && (hcnt == H_LAST) && (vcnt == V_VIS_LAST);

  always_comb begin
    state_nxt = state;
    go_swap   = 1'b0;
    unique case (state)
      SW_IDLE: begin
        if (vblank_entry && swapReq) begin
          state_nxt = SW_SWAP;
          go_swap   = 1'b1;
        end
      end
      SW_SWAP:     state_nxt = SW_WAIT_LOW;
      SW_WAIT_LOW: if (!swapReq) state_nxt = SW_IDLE;
      default:     state_nxt = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SW_IDLE;
      bufSel <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go_swap) bufSel <= !bufSel;
    end
  end

  assign swapAck = (state == SW_SWAP);

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader: two instances (read latency 1 with clear, latency 3 without) on a
// shrunken raster, checked every clk against a pixel-index model of timing, colour, clear and swap.
module tb_vga_scanout_reader;
  localparam int HV = 16, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int LA = 1, LB = 3;

  logic clk = 1'b0;
  logic rst, pix_en, swap_req;
  logic [3:0]  rd_data_a, rd_data_b;
  logic        rd_en_a, clr_we_a, buf_sel_a, swap_ack_a, frame_start_a, hsync_a, vsync_a, blank_a;
  logic        rd_en_b, clr_we_b, buf_sel_b, swap_ack_b, frame_start_b, hsync_b, vsync_b, blank_b;
  logic [18:0] rd_addr_a, clr_addr_a, rd_addr_b, clr_addr_b;
  logic [3:0]  color_a, color_b;

  always #5 clk = ~clk;

  vga_scanout_reader #(.H_VIS(HV), .H_FP(HF), .H_SYN(HS), .H_BP(HB), .V_VIS(VV), .V_FP(VF),
                       .V_SYN(VS), .V_BP(VB), .RD_LAT(LA), .CLR_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .pixEn(pix_en), .rdEn(rd_en_a), .rdAddr(rd_addr_a), .rdData(rd_data_a),
    .clrWe(clr_we_a), .clrAddr(clr_addr_a), .bufSel(buf_sel_a), .swapReq(swap_req),
    .swapAck(swap_ack_a), .frameStart(frame_start_a), .hsync(hsync_a), .vsync(vsync_a),
    .blank(blank_a), .vgaColor(color_a));

  vga_scanout_reader #(.H_VIS(HV), .H_FP(HF), .H_SYN(HS), .H_BP(HB), .V_VIS(VV), .V_FP(VF),
                       .V_SYN(VS), .V_BP(VB), .RD_LAT(LB), .CLR_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .pixEn(pix_en), .rdEn(rd_en_b), .rdAddr(rd_addr_b), .rdData(rd_data_b),
    .clrWe(clr_we_b), .clrAddr(clr_addr_b), .bufSel(buf_sel_b), .swapReq(swap_req),
    .swapAck(swap_ack_b), .frameStart(frame_start_b), .hsync(hsync_b), .vsync(vsync_b),
    .blank(blank_b), .vgaColor(color_b));

  int checks = 0, failures = 0;
  int cyc, k, swap_cyc;
  bit armed, exp_buf;
  bit ev_vld [64], ev_hs [64], ev_vs [64], ev_vis [64], ev_rd [64];
  logic [18:0] ev_addr [64];
  logic [3:0]  ev_col [64];
  bit ea_hs, ea_vs, ea_blank, eb_hs, eb_vs, eb_blank;
  logic [3:0] ea_col, eb_col, salt, prev_col_a;
  int ack_cnt, clr_cnt, a_cnt;

  function automatic logic [3:0] mem_val(input logic [18:0] a);
    logic [3:0] v;
    if (a == 19'd641) return 4'hA;
    v = a[3:0] ^ a[7:4] ^ salt;
    if (v == 4'hA) v = 4'h5;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d, pixel %0d)", tag, obs, exp, cyc, k);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      ev_vld[i] = 1'b0; ev_rd[i] = 1'b0; ev_hs[i] = 1'b1; ev_vs[i] = 1'b1; ev_vis[i] = 1'b0;
      ev_addr[i] = '0; ev_col[i] = '0;
    end
    k = 0; exp_buf = 1'b0; armed = 1'b1; swap_cyc = -100;
    ea_hs = 1'b1; ea_vs = 1'b1; ea_blank = 1'b1; ea_col = '0;
    eb_hs = 1'b1; eb_vs = 1'b1; eb_blank = 1'b1; eb_col = '0;
  endtask

  task automatic rst_chk();
    chk("rst_hsync_a", hsync_a, 1);      chk("rst_hsync_b", hsync_b, 1);
    chk("rst_vsync_a", vsync_a, 1);      chk("rst_vsync_b", vsync_b, 1);
    chk("rst_blank_a", blank_a, 1);      chk("rst_blank_b", blank_b, 1);
    chk("rst_color_a", color_a, 0);      chk("rst_color_b", color_b, 0);
    chk("rst_rd_en_a", rd_en_a, 0);      chk("rst_rd_en_b", rd_en_b, 0);
    chk("rst_clr_we_a", clr_we_a, 0);    chk("rst_buf_sel_a", buf_sel_a, 0);
    chk("rst_buf_sel_b", buf_sel_b, 0);  chk("rst_swap_ack_a", swap_ack_a, 0);
    chk("rst_frame_start_a", frame_start_a, 0);
  endtask

  task automatic tick(input bit pe);
    int ia, ib, x, y, idx;
    bit vpos, vis;
    logic [18:0] addr;
    @(posedge clk); #1;
    pix_en = pe;
    ia = (cyc - LA) & 63;
    ib = (cyc - LB) & 63;
    rd_data_a = ev_rd[ia] ? mem_val(ev_addr[ia]) : 4'($urandom_range(1, 15));
    rd_data_b = ev_rd[ib] ? mem_val(ev_addr[ib]) : 4'($urandom_range(1, 15));
    ia = (cyc - LA - 1) & 63;
    ib = (cyc - LB - 1) & 63;
    if (ev_vld[ia]) begin ea_hs = ev_hs[ia]; ea_vs = ev_vs[ia]; ea_blank = !ev_vis[ia]; ea_col = ev_col[ia]; end
    if (ev_vld[ib]) begin eb_hs = ev_hs[ib]; eb_vs = ev_vs[ib]; eb_blank = !ev_vis[ib]; eb_col = ev_col[ib]; end
    #1;
    x = k % HT;
    y = (k / HT) % VT;
    vpos = (x < HV) && (y < VV);
    vis = pe && vpos;
    addr = vpos ? 19'(x + 640 * y) : '0;
    chk("rd_en_a", rd_en_a, vis);           chk("rd_en_b", rd_en_b, vis);
    chk("rd_addr_a", rd_addr_a, addr);      chk("rd_addr_b", rd_addr_b, addr);
    chk("frame_start_a", frame_start_a, pe && (k % FR == 0));
    chk("frame_start_b", frame_start_b, pe && (k % FR == 0));
    chk("hsync_a", hsync_a, ea_hs);         chk("hsync_b", hsync_b, eb_hs);
    chk("vsync_a", vsync_a, ea_vs);         chk("vsync_b", vsync_b, eb_vs);
    chk("blank_a", blank_a, ea_blank);      chk("blank_b", blank_b, eb_blank);
    chk("color_a", color_a, ea_col);        chk("color_b", color_b, eb_col);
    ia = (cyc - LA) & 63;
    chk("clr_we_a", clr_we_a, ev_rd[ia]);
    if (ev_rd[ia]) chk("clr_addr_a", clr_addr_a, ev_addr[ia]);
    chk("clr_we_b", clr_we_b, 0);           chk("clr_addr_b", clr_addr_b, 0);
    chk("swap_ack_a", swap_ack_a, cyc == swap_cyc + 1);
    chk("swap_ack_b", swap_ack_b, cyc == swap_cyc + 1);
    chk("buf_sel_a", buf_sel_a, exp_buf);   chk("buf_sel_b", buf_sel_b, exp_buf);
    if (swap_ack_a === 1'b1) ack_cnt++;
    if (clr_we_a === 1'b1) clr_cnt++;
    if (color_a === 4'hA && prev_col_a !== 4'hA) a_cnt++;
    prev_col_a = color_a;
    idx = cyc & 63;
    ev_vld[idx]  = pe;
    ev_hs[idx]   = !((x >= HV + HF) && (x < HV + HF + HS));
    ev_vs[idx]   = !((y >= VV + VF) && (y < VV + VF + VS));
    ev_vis[idx]  = vpos;
    ev_rd[idx]   = vis;
    ev_addr[idx] = addr;
    ev_col[idx]  = vpos ? mem_val(addr) : 4'h0;
    // One swap per request: after a swap, swapReq must be seen low before the next vblank entry counts.
    if (pe && x == HT - 1 && y == VV - 1 && armed && swap_req) begin
      exp_buf = !exp_buf; swap_cyc = cyc; armed = 1'b0;
    end else if (!swap_req && cyc >= swap_cyc + 2) begin
      armed = 1'b1;
    end
    if (pe) k++;
    cyc++;
  endtask

  task automatic pixel();
    tick(1'b1);
    repeat ($urandom_range(1, 2)) tick(1'b0);
  endtask

  task automatic advance_to(input int target);
    int guard = 0;
    while (k != target && guard < 5000) begin pixel(); guard++; end
    if (k != target) begin
      failures++;
      $error("FAIL advance_bound observed=%0d expected=%0d", k, target);
    end
  endtask

  int c0, c1, a0, a1;

  initial begin
    rst = 1'b1; pix_en = 1'b1; swap_req = 1'b0; rd_data_a = '0; rd_data_b = '0;
    salt = 4'($urandom); cyc = 100; ack_cnt = 0; clr_cnt = 0; a_cnt = 0; prev_col_a = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1; rst_chk();
    @(posedge clk); #1;
    pix_en = 1'b0; rst = 1'b0;

    advance_to(2 * HT);            swap_req = 1'b1;
    advance_to(FR);                c0 = clr_cnt; a0 = a_cnt;
    advance_to(FR + 3 * HT);       swap_req = 1'b0;
    advance_to(FR + 7 * HT);       swap_req = 1'b1;
    advance_to(2 * FR);            c1 = clr_cnt; a1 = a_cnt;
    chk("clears_per_frame", c1 - c0, HV * VV);
    chk("color_a_once", a1 - a0, 1);
    advance_to(3 * FR);            swap_req = 1'b0;
    advance_to(3 * FR + 2 * HT);   swap_req = 1'b1;
    advance_to(4 * FR + 3 * HT + 5);
    chk("swap_ack_count", ack_cnt, 3);
    chk("buf_sel_before_rst", buf_sel_a, 1);

    rst = 1'b1; pix_en = 1'b1; swap_req = 1'b0;
    #1; model_clear(); rst_chk();
    repeat (2) @(posedge clk);
    #1; pix_en = 1'b0; rst = 1'b0;
    advance_to(2 * HT + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
